// File: rtl/decode_execute_reg.sv
// ID/EX pipeline register: captures decoded control, operands and register addresses with stall/flush.
// Optional performance counters (BubbleCntE, StallCntE) are enabled by defining IDEX_PERF_CNT_EN.
module decode_execute_reg #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidD,
  input  logic              StallE,
  input  logic              FlushE,
  input  logic              RegWriteD,
  input  logic              ALUSrcD,
  input  logic              MemWriteD,
  input  logic              ResultSrcD,
  input  logic              BranchD,
  input  logic [2:0]        ALUControlD,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic [REG_AW-1:0] RS1D,
  input  logic [REG_AW-1:0] RS2D,
  input  logic [REG_AW-1:0] RDD,
  output logic              ValidE,
  output logic              RegWriteE,
  output logic              ALUSrcE,
  output logic              MemWriteE,
  output logic              ResultSrcE,
  output logic              BranchE,
  output logic [2:0]        ALUControlE,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [REG_AW-1:0] RS1E,
  output logic [REG_AW-1:0] RS2E,
  output logic [REG_AW-1:0] RDE
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  BubbleCntE,
  output logic [CNT_W-1:0]  StallCntE
`endif
);

  typedef enum logic {
    BUBBLE = 1'b0,
    LOADED = 1'b1
  } slot_state_t;

  slot_state_t state;

  assign ValidE = (state == LOADED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BUBBLE;
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      RS1E        <= '0;
      RS2E        <= '0;
      RDE         <= '0;
    end else if (FlushE) begin
      // Bubble clears every field, not just the side-effect bits, so traces stay deterministic.
      state       <= BUBBLE;
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      RD1E        <= '0;
      RD2E        <= '0;
      ImmExtE     <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
      RS1E        <= '0;
      RS2E        <= '0;
      RDE         <= '0;
    end else if (!StallE) begin
      state       <= ValidD ? LOADED : BUBBLE;
      RegWriteE   <= RegWriteD & ValidD;
      ALUSrcE     <= ALUSrcD;
      MemWriteE   <= MemWriteD & ValidD;
      ResultSrcE  <= ResultSrcD;
      BranchE     <= BranchD & ValidD;
      ALUControlE <= ALUControlD;
      RD1E        <= RD1D;
      RD2E        <= RD2D;
      ImmExtE     <= ImmExtD;
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
      RS1E        <= RS1D;
      RS2E        <= RS2D;
      RDE         <= RDD;
    end
  end

`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      BubbleCntE <= '0;
      StallCntE  <= '0;
    end else begin
      if (FlushE || (!StallE && !ValidD))
        BubbleCntE <= BubbleCntE + 1'b1;
      if (StallE && !FlushE)
        StallCntE <= StallCntE + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_decode_execute_reg.sv
// Self-checking bench for decode_execute_reg: vector table plus reset and counter sequences.
// Counter checks run only when IDEX_PERF_CNT_EN is defined.
module tb_decode_execute_reg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              rst;
  logic              ValidD, StallE, FlushE;
  logic              RegWriteD, ALUSrcD, MemWriteD, ResultSrcD, BranchD;
  logic [2:0]        ALUControlD;
  logic [XLEN-1:0]   RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [REG_AW-1:0] RS1D, RS2D, RDD;
  logic              ValidE, RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]        ALUControlE;
  logic [XLEN-1:0]   RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [REG_AW-1:0] RS1E, RS2E, RDE;
`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0]  BubbleCntE, StallCntE;
`endif

  int checks = 0;
  int errors = 0;

  decode_execute_reg #(
    .XLEN  (XLEN),
    .REG_AW(REG_AW),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ValidD     (ValidD),
    .StallE     (StallE),
    .FlushE     (FlushE),
    .RegWriteD  (RegWriteD),
    .ALUSrcD    (ALUSrcD),
    .MemWriteD  (MemWriteD),
    .ResultSrcD (ResultSrcD),
    .BranchD    (BranchD),
    .ALUControlD(ALUControlD),
    .RD1D       (RD1D),
    .RD2D       (RD2D),
    .ImmExtD    (ImmExtD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .RS1D       (RS1D),
    .RS2D       (RS2D),
    .RDD        (RDD),
    .ValidE     (ValidE),
    .RegWriteE  (RegWriteE),
    .ALUSrcE    (ALUSrcE),
    .MemWriteE  (MemWriteE),
    .ResultSrcE (ResultSrcE),
    .BranchE    (BranchE),
    .ALUControlE(ALUControlE),
    .RD1E       (RD1E),
    .RD2E       (RD2E),
    .ImmExtE    (ImmExtE),
    .PCE        (PCE),
    .PCPlus4E   (PCPlus4E),
    .RS1E       (RS1E),
    .RS2E       (RS2E),
    .RDE        (RDE)
`ifdef IDEX_PERF_CNT_EN
    ,
    .BubbleCntE (BubbleCntE),
    .StallCntE  (StallCntE)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Secondary data fields are derived from rd1/rdd so one table column covers all of them.
  typedef struct {
    logic        fl, st, vd, rw, mw, br, rs, as;
    logic [2:0]  alu;
    logic [31:0] rd1;
    logic [4:0]  rdd;
    logic        e_v, e_rw, e_mw, e_br, e_rs, e_as;
    logic [2:0]  e_alu;
    logic [31:0] e_rd1;
    logic [4:0]  e_rdd;
    logic        e_clr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    FlushE      = v.fl;
    StallE      = v.st;
    ValidD      = v.vd;
    RegWriteD   = v.rw;
    MemWriteD   = v.mw;
    BranchD     = v.br;
    ResultSrcD  = v.rs;
    ALUSrcD     = v.as;
    ALUControlD = v.alu;
    RD1D        = v.rd1;
    RD2D        = v.rd1 ^ 32'hFFFF_0000;
    ImmExtD     = v.rd1 + 32'd1;
    PCD         = v.rd1 << 2;
    PCPlus4D    = (v.rd1 << 2) + 32'd4;
    RS1D        = v.rdd + 5'd1;
    RS2D        = v.rdd + 5'd2;
    RDD         = v.rdd;
  endtask

  task automatic check_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    chk({p, ".ValidE"},      ValidE,      v.e_v);
    chk({p, ".RegWriteE"},   RegWriteE,   v.e_rw);
    chk({p, ".MemWriteE"},   MemWriteE,   v.e_mw);
    chk({p, ".BranchE"},     BranchE,     v.e_br);
    chk({p, ".ResultSrcE"},  ResultSrcE,  v.e_rs);
    chk({p, ".ALUSrcE"},     ALUSrcE,     v.e_as);
    chk({p, ".ALUControlE"}, ALUControlE, v.e_alu);
    chk({p, ".RD1E"},        RD1E,        v.e_rd1);
    chk({p, ".RDE"},         RDE,         v.e_rdd);
    chk({p, ".RD2E"},     RD2E,     v.e_clr ? 32'd0 : (v.e_rd1 ^ 32'hFFFF_0000));
    chk({p, ".ImmExtE"},  ImmExtE,  v.e_clr ? 32'd0 : (v.e_rd1 + 32'd1));
    chk({p, ".PCE"},      PCE,      v.e_clr ? 32'd0 : (v.e_rd1 << 2));
    chk({p, ".PCPlus4E"}, PCPlus4E, v.e_clr ? 32'd0 : ((v.e_rd1 << 2) + 32'd4));
    chk({p, ".RS1E"},     RS1E,     v.e_clr ? 5'd0 : (v.e_rdd + 5'd1));
    chk({p, ".RS2E"},     RS2E,     v.e_clr ? 5'd0 : (v.e_rdd + 5'd2));
  endtask

  task automatic add(input logic fl, st, vd, rw, mw, br, rs, as, input logic [2:0] alu,
                     input logic [31:0] rd1, input logic [4:0] rdd,
                     input logic e_v, e_rw, e_mw, e_br, e_rs, e_as, input logic [2:0] e_alu,
                     input logic [31:0] e_rd1, input logic [4:0] e_rdd, input logic e_clr);
    vec_t v;
    v.fl = fl; v.st = st; v.vd = vd; v.rw = rw; v.mw = mw; v.br = br; v.rs = rs; v.as = as;
    v.alu = alu; v.rd1 = rd1; v.rdd = rdd;
    v.e_v = e_v; v.e_rw = e_rw; v.e_mw = e_mw; v.e_br = e_br; v.e_rs = e_rs; v.e_as = e_as;
    v.e_alu = e_alu; v.e_rd1 = e_rd1; v.e_rdd = e_rdd; v.e_clr = e_clr;
    vecs.push_back(v);
  endtask

  // Idle inputs: an ordinary valid load of harmless values.
  task automatic idle_inputs();
    vec_t v;
    v = '{default: '0};
    v.vd = 1'b1;
    drive(v);
  endtask

  initial begin
    //    fl st vd rw mw br rs as alu     rd1     rdd    | v rw mw br rs as alu     rd1     rdd  clr
    add(0, 0, 1, 1, 0, 0, 0, 1, 3'b010, 32'h5,  5'd7,    1, 1, 0, 0, 0, 1, 3'b010, 32'h5, 5'd7, 0); // basic load
    add(0, 0, 1, 1, 1, 1, 1, 0, 3'b101, 32'hA,  5'd3,    1, 1, 1, 1, 1, 0, 3'b101, 32'hA, 5'd3, 0); // load A
    add(0, 1, 1, 0, 0, 0, 0, 1, 3'b111, 32'hB,  5'd9,    1, 1, 1, 1, 1, 0, 3'b101, 32'hA, 5'd3, 0); // stall 1
    add(0, 1, 1, 0, 0, 0, 0, 1, 3'b111, 32'hB,  5'd9,    1, 1, 1, 1, 1, 0, 3'b101, 32'hA, 5'd3, 0); // stall 2
    add(0, 1, 1, 0, 0, 0, 0, 1, 3'b111, 32'hB,  5'd9,    1, 1, 1, 1, 1, 0, 3'b101, 32'hA, 5'd3, 0); // stall 3
    add(0, 0, 1, 0, 0, 0, 0, 1, 3'b111, 32'hB,  5'd9,    1, 0, 0, 0, 0, 1, 3'b111, 32'hB, 5'd9, 0); // release -> B
    add(0, 0, 1, 1, 1, 0, 1, 1, 3'b001, 32'hC,  5'd4,    1, 1, 1, 0, 1, 1, 3'b001, 32'hC, 5'd4, 0); // load store
    add(1, 1, 1, 1, 1, 1, 1, 1, 3'b011, 32'hD,  5'd5,    0, 0, 0, 0, 0, 0, 3'b000, 32'h0, 5'd0, 1); // flush+stall
    add(0, 0, 0, 1, 1, 1, 1, 1, 3'b110, 32'hE,  5'd6,    0, 0, 0, 0, 1, 1, 3'b110, 32'hE, 5'd6, 0); // invalid slot
    add(0, 0, 1, 1, 0, 0, 0, 0, 3'b100, 32'h11, 5'd10,   1, 1, 0, 0, 0, 0, 3'b100, 32'h11, 5'd10, 0);
    add(1, 0, 1, 1, 1, 1, 1, 1, 3'b111, 32'h12, 5'd11,   0, 0, 0, 0, 0, 0, 3'b000, 32'h0, 5'd0, 1); // flush
    add(0, 1, 1, 1, 1, 1, 1, 1, 3'b111, 32'h13, 5'd12,   0, 0, 0, 0, 0, 0, 3'b000, 32'h0, 5'd0, 1); // stall bubble
    add(0, 0, 1, 1, 0, 0, 0, 0, 3'b000, 32'hF,  5'd0,    1, 1, 0, 0, 0, 0, 3'b000, 32'hF, 5'd0, 0); // x0 write
    add(0, 1, 0, 0, 0, 0, 0, 1, 3'b010, 32'h14, 5'd13,   1, 1, 0, 0, 0, 0, 3'b000, 32'hF, 5'd0, 0); // stall ignores invalid

    rst = 1'b0;
    idle_inputs();
    #12;
    chk("reset.ValidE",      ValidE,      1'b0);
    chk("reset.RegWriteE",   RegWriteE,   1'b0);
    chk("reset.ALUControlE", ALUControlE, 3'b000);
    chk("reset.RD1E",        RD1E,        32'd0);
    chk("reset.PCPlus4E",    PCPlus4E,    32'd0);
    chk("reset.RDE",         RDE,         5'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      check_vec(i, vecs[i]);
    end

    // Asynchronous reset mid-cycle while a valid instruction sits in E.
    @(negedge clk);
    drive(vecs[6]);
    @(posedge clk);
    #1;
    chk("preasync.ValidE", ValidE, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("async.ValidE",    ValidE,    1'b0);
    chk("async.MemWriteE", MemWriteE, 1'b0);
    chk("async.RD1E",      RD1E,      32'd0);
    chk("async.ImmExtE",   ImmExtE,   32'd0);
    chk("async.RDE",       RDE,       5'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(vecs[0]);
    @(posedge clk);
    #1;
    check_vec(100, vecs[0]);

`ifdef IDEX_PERF_CNT_EN
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("cnt.reset.bubble", BubbleCntE, 4'd0);
    chk("cnt.reset.stall",  StallCntE,  4'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      FlushE = 1'b1; StallE = 1'b0;
      @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      FlushE = 1'b0; StallE = 1'b1;
      @(negedge clk);
    end
    FlushE = 1'b1; StallE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0; StallE = 1'b0;
    chk("cnt.bubble5", BubbleCntE, 4'd5);
    chk("cnt.stall2",  StallCntE,  4'd2);
    // Invalid normal load is a bubble too.
    ValidD = 1'b0;
    @(negedge clk);
    ValidD = 1'b1;
    chk("cnt.invalid6", BubbleCntE, 4'd6);
    FlushE = 1'b1;
    for (int i = 0; i < 9; i++) @(negedge clk);
    FlushE = 1'b0;
    chk("cnt.bubble_max", BubbleCntE, 4'hF);
    FlushE = 1'b1;
    @(negedge clk);
    FlushE = 1'b0;
    chk("cnt.bubble_wrap", BubbleCntE, 4'h0);
    chk("cnt.stall_hold",  StallCntE,  4'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, limit 100000 expected earlier");
    $fatal(1, "timeout");
  end

endmodule
